// File: rtl/tmp_pkg.sv
// tmp_pkg: shared state encoding, default widths and saturating trim for the temperature decimator
package tmp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COLLECT, S_ACCUM, S_PRESENT} state_t;
  localparam int DEF_OSR_LOG2 = 6;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_CODE_W = 10;
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
    return a < b ? '0 : ((a - b) > max ? max : a - b);
  endfunction
endpackage

// File: rtl/tmp_code_reg.sv
// tmp_code_reg: one-deep valid/ready result register with sticky overrun on dropped results
module tmp_code_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         code_ready,
  input  logic         clr_overrun,
  output logic [W-1:0] code,
  output logic         code_valid,
  output logic         overrun
);
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d, ovr_q, ovr_d, take;
  always_comb begin
    take = load & (~valid_q | code_ready);
    code_d = take ? din : code_q;
    valid_d = take | (valid_q & ~code_ready);
    ovr_d = (load & valid_q & ~code_ready) | (ovr_q & ~clr_overrun);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      code_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      code_q <= code_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  assign code = code_q;
  assign code_valid = valid_q;
  assign overrun = ovr_q;
endmodule

// File: rtl/tmp_decim.sv
// tmp_decim: counts comparator ones per window, averages conversions and presents a trimmed code
module tmp_decim
  import tmp_pkg::*;
#(
  parameter int          OSR_LOG2 = DEF_OSR_LOG2,
  parameter int          AVG_LOG2 = DEF_AVG_LOG2,
  parameter int          SETTLE   = 2,
  parameter int          CODE_W   = DEF_CODE_W,
  parameter int unsigned OFFSET   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  input  logic              sample_stb,
  input  logic              cmp_bit,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);
  localparam int OW = OSR_LOG2 + 1;
  localparam int AW = OW + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int SW = $clog2(SETTLE + 2);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE > 0 ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] CLAST = CW'((1 << AVG_LOG2) - 1);
  localparam state_t ENTRY = SETTLE > 0 ? S_SETTLE : S_COLLECT;
  localparam logic [31:0] CMAX = 32'((64'd1 << CODE_W) - 1);
  if (CODE_W < OSR_LOG2 + 1) begin : g_bad_w
    $error("tmp_decim: CODE_W must be at least OSR_LOG2+1");
  end
  state_t               state_q, state_d;
  logic [SW-1:0]        set_q, set_d;
  logic [OSR_LOG2-1:0]  smp_q, smp_d;
  logic [OW-1:0]        ones_q, ones_d;
  logic [CW-1:0]        conv_q, conv_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic                 qs;
  logic [CODE_W-1:0]    result;
  assign qs = sample_stb & en;
  assign result = CODE_W'(sat_sub(32'(acc_q >> AVG_LOG2), OFFSET, CMAX));
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    smp_d = smp_q;
    ones_d = ones_q;
    conv_d = conv_q;
    acc_d = acc_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = ENTRY;
        set_d = '0;
        smp_d = '0;
        ones_d = '0;
        conv_d = '0;
        acc_d = '0;
      end
      S_SETTLE: if (qs) begin
        set_d = set_q + SW'(1);
        state_d = set_q == SLAST ? S_COLLECT : S_SETTLE;
      end
      S_COLLECT: if (qs) begin
        smp_d = smp_q + OSR_LOG2'(1);
        ones_d = ones_q + OW'(cmp_bit);
        state_d = &smp_q ? S_ACCUM : S_COLLECT;
      end
      S_ACCUM: begin
        acc_d = acc_q + AW'(ones_q);
        if (conv_q == CLAST) state_d = S_PRESENT;
        else begin
          conv_d = conv_q + CW'(1);
          ones_d = '0;
          smp_d = '0;
          set_d = '0;
          state_d = ENTRY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      set_q <= '0;
      smp_q <= '0;
      ones_q <= '0;
      conv_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      smp_q <= smp_d;
      ones_q <= ones_d;
      conv_q <= conv_d;
      acc_q <= acc_d;
    end
  assign busy = state_q != S_IDLE;
  tmp_code_reg #(.W(CODE_W)) u_code_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (state_q == S_PRESENT),
    .din         (result),
    .code_ready  (code_ready),
    .clr_overrun (clr_overrun),
    .code        (code),
    .code_valid  (code_valid),
    .overrun     (overrun)
  );
endmodule

// File: tb/tb_tmp_decim.sv
// tb_tmp_decim: directed checks of window counting, averaging, trim, output handshake and reset
module tb_tmp_decim;
  logic       clk = 0, reset = 1, en = 1, sample_stb = 0, cmp_bit = 0, code_ready = 0, clr_overrun = 0;
  logic [2:0] start = '0, valid, busy, ovr;
  logic [9:0] code [3];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  tmp_decim #(.OSR_LOG2(3), .AVG_LOG2(0), .SETTLE(2), .CODE_W(10), .OFFSET(0)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .en(en), .sample_stb(sample_stb), .cmp_bit(cmp_bit),
    .code(code[0]), .code_valid(valid[0]), .code_ready(code_ready), .busy(busy[0]), .overrun(ovr[0]),
    .clr_overrun(clr_overrun));
  tmp_decim #(.OSR_LOG2(3), .AVG_LOG2(1), .SETTLE(2), .CODE_W(10), .OFFSET(0)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .en(en), .sample_stb(sample_stb), .cmp_bit(cmp_bit),
    .code(code[1]), .code_valid(valid[1]), .code_ready(code_ready), .busy(busy[1]), .overrun(ovr[1]),
    .clr_overrun(clr_overrun));
  tmp_decim #(.OSR_LOG2(3), .AVG_LOG2(0), .SETTLE(2), .CODE_W(10), .OFFSET(5)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .en(en), .sample_stb(sample_stb), .cmp_bit(cmp_bit),
    .code(code[2]), .code_valid(valid[2]), .code_ready(code_ready), .busy(busy[2]), .overrun(ovr[2]),
    .clr_overrun(clr_overrun));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic stb(input logic b);
    sample_stb = 1;
    cmp_bit = b;
    @(negedge clk);
    sample_stb = 0;
    cmp_bit = 0;
  endtask
  task automatic kick(input int i);
    start[i] = 1;
    @(negedge clk);
    start[i] = 0;
  endtask
  task automatic meas(input int i, input logic [7:0] bits);
    kick(i);
    stb(1);
    stb(1);
    for (int k = 7; k >= 0; k--) stb(bits[k]);
  endtask
  task automatic consume();
    code_ready = 1;
    @(negedge clk);
    code_ready = 0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_code", 32'(code[0]), 0);
    chk("rst_valid", 32'(valid[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_ovr", 32'(ovr[0]), 0);
    reset = 0;
    @(negedge clk);
    kick(0);
    chk("t1_busy", 32'(busy[0]), 1);
    repeat (10) stb(1);
    chk("t1_valid_lat1", 32'(valid[0]), 0);
    @(negedge clk);
    chk("t1_valid_lat2", 32'(valid[0]), 0);
    @(negedge clk);
    chk("t1_valid", 32'(valid[0]), 1);
    chk("t1_code", 32'(code[0]), 8);
    chk("t1_busy_done", 32'(busy[0]), 0);
    consume();
    chk("t1_valid_drop", 32'(valid[0]), 0);
    kick(0);
    stb(0);
    stb(0);
    stb(1); stb(0); stb(1); stb(0);
    en = 0;
    sample_stb = 1;
    cmp_bit = 1;
    repeat (5) @(negedge clk);
    sample_stb = 0;
    en = 1;
    chk("t2_pause_busy", 32'(busy[0]), 1);
    chk("t2_pause_valid", 32'(valid[0]), 0);
    stb(1); stb(0); stb(1); stb(0);
    repeat (2) @(negedge clk);
    chk("t2_valid", 32'(valid[0]), 1);
    chk("t2_code", 32'(code[0]), 4);
    consume();
    meas(1, 8'b1111_1100);
    @(negedge clk);
    chk("t3_mid_busy", 32'(busy[1]), 1);
    stb(1);
    stb(1);
    for (int k = 7; k >= 0; k--) stb(k < 3);
    @(negedge clk);
    chk("t3_valid_lat1", 32'(valid[1]), 0);
    @(negedge clk);
    chk("t3_valid", 32'(valid[1]), 1);
    chk("t3_code", 32'(code[1]), 4);
    consume();
    meas(2, 8'b1010_1000);
    repeat (2) @(negedge clk);
    chk("t4_valid", 32'(valid[2]), 1);
    chk("t4_code_sat", 32'(code[2]), 0);
    consume();
    meas(0, 8'hFF);
    repeat (2) @(negedge clk);
    meas(0, 8'b0100_0001);
    repeat (2) @(negedge clk);
    chk("t5_code_kept", 32'(code[0]), 8);
    chk("t5_valid_kept", 32'(valid[0]), 1);
    chk("t5_ovr", 32'(ovr[0]), 1);
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;
    chk("t5_ovr_clr", 32'(ovr[0]), 0);
    chk("t5_code_after_clr", 32'(code[0]), 8);
    meas(0, 8'b0000_0011);
    @(negedge clk);
    code_ready = 1;
    @(negedge clk);
    code_ready = 0;
    chk("t5_code_swap", 32'(code[0]), 2);
    chk("t5_valid_swap", 32'(valid[0]), 1);
    chk("t5_ovr_swap", 32'(ovr[0]), 0);
    meas(0, 8'h00);
    @(negedge clk);
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;
    chk("t5_set_wins", 32'(ovr[0]), 1);
    chk("t5_code_hold", 32'(code[0]), 2);
    consume();
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;
    kick(0);
    stb(1);
    stb(1);
    repeat (4) stb(1);
    reset = 1;
    #1;
    chk("t6_rst_busy", 32'(busy[0]), 0);
    chk("t6_rst_valid", 32'(valid[0]), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    kick(0);
    start[0] = 1;
    stb(0);
    start[0] = 0;
    stb(0);
    repeat (3) stb(0);
    start[0] = 1;
    stb(0);
    start[0] = 0;
    repeat (4) stb(0);
    @(negedge clk);
    chk("t6_valid_lat1", 32'(valid[0]), 0);
    @(negedge clk);
    chk("t6_valid", 32'(valid[0]), 1);
    chk("t6_code", 32'(code[0]), 0);
    chk("t6_idle", 32'(busy[0]), 0);
    consume();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tmp_decim.md
Name: tmp_decim

Overview:
- Downstream consumer of the temperature-sensor phase controller's comparator bitstream.
- While the controller's balancing phase is active, the controller toggles source/sink charge on each comparator decision. This block counts the comparator ones over a fixed window.
- It averages the window counts over several conversions, removes a trim offset, and presents a saturated temperature code on a valid/ready interface to the readout/register block.

Parameters:
- OSR_LOG2, 6, log2 of the number of counted comparator samples per conversion.
- AVG_LOG2, 2, log2 of the number of conversions averaged per output code.
- SETTLE, 2, number of leading strobes discarded at the start of each conversion.
- CODE_W, 10, output code width; must be >= OSR_LOG2+1 (elaboration error otherwise).
- OFFSET, 0, unsigned trim subtracted from the averaged count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a measurement of 2^AVG_LOG2 conversions.
- en  input  1  controller balancing phase active; strobes are counted only while high.
- sample_stb  input  1  comparator decision strobe.
- cmp_bit  input  1  comparator decision; qualified by sample_stb & en.
- code  output  CODE_W  averaged, trimmed temperature code.
- code_valid  output  1  code holds an unconsumed result.
- code_ready  input  1  consumer accepts code when high together with code_valid.
- busy  output  1  measurement in progress (state is not IDLE).
- overrun  output  1  sticky: a result was dropped because the output register was full.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, active-high): state=IDLE, all counters and the accumulator 0, code=0, code_valid=0, busy=0, overrun=0. Reset mid-conversion abandons the measurement with no partial output.
- Qualified sample: sample_stb & en in the same posedge. While en is low, strobes are ignored and the counters hold (pause, not abort).
- IDLE: start moves to SETTLE and clears the sample counter, ones counter, conversion counter and accumulator. start while busy is ignored.
- SETTLE: discards SETTLE qualified samples, then moves to COLLECT. SETTLE=0 goes directly to COLLECT.
- COLLECT: for each qualified sample, increment the sample counter and add cmp_bit to the ones counter (width OSR_LOG2+1, range 0..2^OSR_LOG2). On the 2^OSR_LOG2-th qualified sample, move to ACCUM; that sample's bit is included.
- ACCUM (1 cycle): accumulator += ones; accumulator width OSR_LOG2+1+AVG_LOG2, no overflow possible.
  - If the conversion counter has reached 2^AVG_LOG2-1, move to PRESENT.
  - Otherwise increment the conversion counter, clear the ones and sample counters, and return to SETTLE.
- PRESENT (1 cycle): result = (acc >> AVG_LOG2) - OFFSET, saturated to 0 if negative and to 2^CODE_W-1 if above it. Truncation of the shift is floor. Then return to IDLE.
- Latency: code_valid rises 2 cycles after the posedge that captured the final qualified sample (ACCUM, then PRESENT, then register).
- Output register, one deep:
  - Load on PRESENT if code_valid=0, or if code_valid & code_ready in the same cycle. The latter case accepts the old result and loads the new one, and does not set overrun.
  - If code_valid=1 and code_ready=0 at PRESENT: keep the old code, drop the new one, set overrun=1.
  - code_valid falls the cycle after code_valid & code_ready when no new load occurs.
  - code and code_valid are stable while code_valid=1 and code_ready=0.
- overrun: clr_overrun clears it. If a set and clr_overrun coincide in the same cycle, the set wins.
- busy = (state != IDLE). The output register is independent of busy, so a new measurement may start while code is still pending.
- A new start in the same cycle that PRESENT returns to IDLE is ignored; start is only sampled in IDLE.

Decomposition:
- Shared package tmp_pkg:
  - state enum (IDLE, SETTLE, COLLECT, ACCUM, PRESENT).
  - default OSR_LOG2/AVG_LOG2/CODE_W constants, shared with the controller and readout.
  - saturating-subtract function.
- One sub-module, tmp_code_reg: the one-deep valid/ready output register with overrun detection. The FSM and counters stay in tmp_decim.

Test Plan:
- OSR_LOG2=3, AVG_LOG2=0, SETTLE=2, OFFSET=0; start, 10 strobes with en=1 and cmp_bit=1 -> code=8, code_valid 2 cycles after the 10th strobe, busy low thereafter.
- Same configuration, cmp_bit alternating 1,0 after settle, with en dropped for 5 cycles mid-window carrying strobes -> paused strobes ignored, code=4.
- AVG_LOG2=1; conversion 1 has 6 ones, conversion 2 has 3 ones -> acc=9, code=4. OFFSET=5 with a single conversion of 3 ones -> code=0 (saturated).
- code_ready held 0 across two complete measurements (results 8, then 2) -> code stays 8, overrun=1; clr_overrun -> overrun=0. Repeat with code_ready=1 exactly at the second PRESENT -> code=2, overrun stays 0.
- Assert reset mid-COLLECT after 4 ones, then start with all-zero bits -> code=0, no stale count; start pulsed while busy -> no effect on the result or timing.
